// File: rtl/mul_arb_pkg.sv
// Shared types, widths and the rotating-priority pick helper for mul_share_arbiter.
package mul_arb_pkg;

    localparam int OP_W    = 4;
    localparam int PROD_W  = 8;
    localparam int MAX_REQ = 8;
    localparam int PTR_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // Descending scan so the candidate closest to ptr is the one left standing.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [PTR_W-1:0]   ptr,
                                         input int                 nreq);
        rr_pick_t         res;
        int               pos;
        logic [PTR_W-1:0] pidx;
        res.found = 1'b0;
        res.idx   = {PTR_W{1'b0}};
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                pos  = (int'(ptr) + k) % nreq;
                pidx = PTR_W'(pos);
                if (valid[pidx]) begin
                    res.found = 1'b1;
                    res.idx   = pidx;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// Combinational rotating-priority picker: first active request at or after ptr_i.
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            found_o
);

    logic [MAX_REQ-1:0] valid_ext_s;
    logic [PTR_W-1:0]   ptr_ext_s;
    rr_pick_t           pick_s;

    // Widen to the helper's fixed size, pick, then build the one-hot grant.
    always_comb begin
        valid_ext_s             = {MAX_REQ{1'b0}};
        valid_ext_s[NREQ-1:0]   = req_i;
        ptr_ext_s               = PTR_W'(ptr_i);
        pick_s                  = rr_pick(valid_ext_s, ptr_ext_s, NREQ);
        found_o                 = pick_s.found;
        idx_o                   = IDW'(pick_s.idx);
        if (pick_s.found) begin
            grant_o = NREQ'(1) << pick_s.idx;
        end else begin
            grant_o = {NREQ{1'b0}};
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one 4x4 multiplier between NREQ requesters.
// Optional per-requester response counters via MUL_ARB_STATS_EN.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int MUL_LAT = 1,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [OP_W*NREQ-1:0]   req_num1,
    input  logic [OP_W*NREQ-1:0]   req_num2,
    output logic [OP_W-1:0]        mul_num1,
    output logic [OP_W-1:0]        mul_num2,
    input  logic [PROD_W-1:0]      mul_in,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [PROD_W-1:0]      rsp_mul,
    output logic                   busy
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [8*NREQ-1:0]      grant_cnt
`endif
);

    generate
        if (MUL_LAT < 0 || MUL_LAT > 7) begin : g_bad_lat
            $error("mul_share_arbiter: MUL_LAT must be within 0..7");
        end
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("mul_share_arbiter: NREQ must be within 2..8");
        end
    endgenerate

    localparam logic [2:0] LAT_INIT = 3'(MUL_LAT);

    arb_state_e          state_q;
    logic [IDW-1:0]      rr_ptr_q;
    logic [IDW-1:0]      rr_ptr_d;
    logic [OP_W-1:0]     op1_q;
    logic [OP_W-1:0]     op2_q;
    logic [IDW-1:0]      rsp_id_q;
    logic [PROD_W-1:0]   rsp_mul_q;
    logic [2:0]          lat_cnt_q;
    logic                rsp_valid_q;
    logic                busy_q;

    logic [NREQ-1:0]     grant_s;
    logic [IDW-1:0]      gidx_s;
    logic                found_s;
    logic [OP_W-1:0]     gnt_num1_s;
    logic [OP_W-1:0]     gnt_num2_s;
    logic                rsp_hs_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_s),
        .idx_o   (gidx_s),
        .found_o (found_s)
    );

    assign gnt_num1_s = req_num1[gidx_s*OP_W +: OP_W];
    assign gnt_num2_s = req_num2[gidx_s*OP_W +: OP_W];
    assign rsp_hs_s   = rsp_valid_q & rsp_ready;

    // Ready is offered only while idle; the requester just served drops to lowest priority next.
    always_comb begin
        if (state_q == IDLE) begin
            req_ready = grant_s;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
        if (rsp_id_q == IDW'(NREQ - 1)) begin
            rr_ptr_d = {IDW{1'b0}};
        end else begin
            rr_ptr_d = rsp_id_q + IDW'(1);
        end
    end

    // Grant / settle / respond sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= {IDW{1'b0}};
            op1_q       <= {OP_W{1'b0}};
            op2_q       <= {OP_W{1'b0}};
            rsp_id_q    <= {IDW{1'b0}};
            rsp_mul_q   <= {PROD_W{1'b0}};
            lat_cnt_q   <= 3'd0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_s) begin
                        op1_q     <= gnt_num1_s;
                        op2_q     <= gnt_num2_s;
                        rsp_id_q  <= gidx_s;
                        lat_cnt_q <= LAT_INIT;
                        busy_q    <= 1'b1;
                        state_q   <= WAIT;
                    end else begin
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                WAIT: begin
                    if (lat_cnt_q != 3'd0) begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                    end else begin
                        rsp_mul_q   <= mul_in;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign mul_num1  = op1_q;
    assign mul_num2  = op2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_mul   = rsp_mul_q;
    assign busy      = busy_q;

`ifdef MUL_ARB_STATS_EN
    logic [7:0] cnt_q [NREQ];

    // Saturating per-requester count of completed response handshakes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else if (rsp_hs_s && (cnt_q[rsp_id_q] != 8'hFF)) begin
            cnt_q[rsp_id_q] <= cnt_q[rsp_id_q] + 8'd1;
        end else begin
            cnt_q[0] <= cnt_q[0];
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt_out
        assign grant_cnt[8*gi +: 8] = cnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter (NREQ=4, MUL_LAT=1) plus MUL_LAT=0/7 latency instances.
module tb_mul_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = 4'd0;
    logic [3:0]  req_ready;
    logic [15:0] req_num1 = 16'd0;
    logic [15:0] req_num2 = 16'd0;
    logic [3:0]  mul_num1, mul_num2;
    logic [7:0]  mul_in;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_mul;
    logic        busy;

    logic [1:0]  l_valid = 2'd0;
    logic [7:0]  l_num1 = 8'd0, l_num2 = 8'd0;
    logic [1:0]  l0_ready, l7_ready;
    logic [3:0]  l0_n1, l0_n2, l7_n1, l7_n2;
    logic [7:0]  l0_in, l7_in, l0_mul, l7_mul;
    logic        l0_rv, l7_rv, l0_busy, l7_busy;
    logic [0:0]  l0_id, l7_id;
`ifdef MUL_ARB_STATS_EN
    logic [31:0] grant_cnt;
    logic [15:0] l0_cnt, l7_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] mul;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mul_in = {4'd0, mul_num1} * {4'd0, mul_num2};
    assign l0_in  = {4'd0, l0_n1} * {4'd0, l0_n2};
    assign l7_in  = {4'd0, l7_n1} * {4'd0, l7_n2};

    mul_share_arbiter #(.NREQ(4), .MUL_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_num1(req_num1), .req_num2(req_num2), .mul_num1(mul_num1), .mul_num2(mul_num2),
        .mul_in(mul_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_mul(rsp_mul), .busy(busy)
`ifdef MUL_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    mul_share_arbiter #(.NREQ(2), .MUL_LAT(0)) dut_l0 (
        .clk(clk), .rst(rst), .req_valid(l_valid), .req_ready(l0_ready),
        .req_num1(l_num1), .req_num2(l_num2), .mul_num1(l0_n1), .mul_num2(l0_n2),
        .mul_in(l0_in), .rsp_valid(l0_rv), .rsp_ready(1'b1), .rsp_id(l0_id),
        .rsp_mul(l0_mul), .busy(l0_busy)
`ifdef MUL_ARB_STATS_EN
        , .grant_cnt(l0_cnt)
`endif
    );

    mul_share_arbiter #(.NREQ(2), .MUL_LAT(7)) dut_l7 (
        .clk(clk), .rst(rst), .req_valid(l_valid), .req_ready(l7_ready),
        .req_num1(l_num1), .req_num2(l_num2), .mul_num1(l7_n1), .mul_num2(l7_n2),
        .mul_in(l7_in), .rsp_valid(l7_rv), .rsp_ready(1'b1), .rsp_id(l7_id),
        .rsp_mul(l7_mul), .busy(l7_busy)
`ifdef MUL_ARB_STATS_EN
        , .grant_cnt(l7_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic edge_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] mul);
        exp_t e;
        e.id  = id;
        e.mul = mul;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for a grant, compare it, then drop the requested valid bits after the edge.
    task automatic grant_expect(input logic [3:0] exp, input logic [3:0] drop, input string name,
                                output int gcyc);
        int n = 0;
        @(negedge clk);
        while (req_ready == 4'd0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(req_ready), 32'(exp));
        gcyc = cyc;
        edge_drive();
        req_valid = req_valid & ~drop;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 40);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        edge_drive();
        rst = 1'b0;
        req_valid = 4'd0;
        repeat (2) edge_drive();
        rst = 1'b1;
    endtask

    // Scoreboard monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d mul %0d, expected no response", rsp_id, rsp_mul);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                check("rsp_mul", 32'(rsp_mul), 32'(mon_e.mul));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int gc[5];
        int g, n, t0, t7, bad;
        logic [3:0] oh;
        logic [7:0] m0, m7;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mul_num", 32'({mul_num1, mul_num2}), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_id, rsp_mul}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        edge_drive();
        rst = 1'b1;

        // Single request 3*5
        edge_drive();
        req_valid = 4'b0001; req_num1 = 16'h0003; req_num2 = 16'h0005;
        push(2'd0, 8'd15);
        grant_expect(4'b0001, 4'b0001, "t1_ready", g);
        wait_rsp(n);
        check("t1_latency", 32'(n), 32'd3);
        @(negedge clk);
        check("t1_busy_low", 32'(busy), 32'd0);
        wait_idle("t1");

        // All four continuously valid, operands (i+1, 2)
        do_reset();
        edge_drive();
        req_num1 = {4'd4, 4'd3, 4'd2, 4'd1};
        req_num2 = {4'd2, 4'd2, 4'd2, 4'd2};
        req_valid = 4'b1111;
        push(2'd0, 8'd2); push(2'd1, 8'd4); push(2'd2, 8'd6); push(2'd3, 8'd8); push(2'd0, 8'd2);
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            grant_expect(oh, (k == 4) ? 4'b1111 : 4'b0000, "t2_grant", gc[k]);
            if (k > 0) check("t2_spacing", 32'(gc[k] - gc[k-1]), 32'd4);
        end
        wait_idle("t2");

        // 15*15 on id 1 with five cycles of back-pressure; id 3 waits meanwhile
        edge_drive();
        rsp_ready = 1'b0;
        req_num1 = {4'd2, 4'd0, 4'd15, 4'd0};
        req_num2 = {4'd3, 4'd0, 4'd15, 4'd0};
        req_valid = 4'b0010;
        push(2'd1, 8'd225); push(2'd3, 8'd6);
        grant_expect(4'b0010, 4'b0010, "t3_grant1", g);
        req_valid = 4'b1000;
        wait_rsp(n);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            if (!rsp_valid || rsp_mul !== 8'd225 || rsp_id !== 2'd1 || req_ready !== 4'd0) bad++;
        end
        check("t3_backpressure_stable", 32'(bad), 32'd0);
        edge_drive();
        rsp_ready = 1'b1;
        grant_expect(4'b1000, 4'b1000, "t3_grant3", g);
        wait_idle("t3");

        // Round-robin pointer: serve id 2, then 0101 must pick 0 then 2
        edge_drive();
        req_num1 = {4'd0, 4'd4, 4'd0, 4'd0};
        req_num2 = {4'd0, 4'd4, 4'd0, 4'd0};
        req_valid = 4'b0100;
        push(2'd2, 8'd16);
        grant_expect(4'b0100, 4'b0100, "t4_grant2", g);
        wait_idle("t4a");
        edge_drive();
        req_num1 = {4'd0, 4'd5, 4'd0, 4'd1};
        req_num2 = {4'd0, 4'd5, 4'd0, 4'd9};
        req_valid = 4'b0101;
        push(2'd0, 8'd9); push(2'd2, 8'd25);
        grant_expect(4'b0001, 4'b0001, "t4_rr_first", g);
        grant_expect(4'b0100, 4'b0100, "t4_rr_second", g);
        wait_idle("t4b");

        // Reset during WAIT abandons the operation
        edge_drive();
        req_num1 = {4'd0, 4'd0, 4'd7, 4'd0};
        req_num2 = {4'd0, 4'd0, 4'd7, 4'd0};
        req_valid = 4'b0010;
        grant_expect(4'b0010, 4'b0010, "t5_grant", g);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_mul_num", 32'({mul_num1, mul_num2}), 32'd0);
        check("t5_rst_rsp", 32'({rsp_valid, rsp_id, rsp_mul}), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        repeat (2) edge_drive();
        rst = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || busy) bad++;
        end
        check("t5_no_rsp_after_reset", 32'(bad), 32'd0);
        edge_drive();
        req_num1 = {4'd3, 4'd0, 4'd2, 4'd0};
        req_num2 = {4'd3, 4'd0, 4'd3, 4'd0};
        req_valid = 4'b1010;
        push(2'd1, 8'd6); push(2'd3, 8'd9);
        grant_expect(4'b0010, 4'b0010, "t5_grant_after_rst", g);
        grant_expect(4'b1000, 4'b1000, "t5_grant_next", g);
        wait_idle("t5");

        // MUL_LAT=0 and MUL_LAT=7 instances, 6*7
        edge_drive();
        l_num1 = 8'h06; l_num2 = 8'h07; l_valid = 2'b01;
        @(negedge clk);
        check("t6_l0_ready", 32'(l0_ready), 32'd1);
        check("t6_l7_ready", 32'(l7_ready), 32'd1);
        edge_drive();
        l_valid = 2'b00;
        t0 = -1; t7 = -1; m0 = 8'd0; m7 = 8'd0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (l0_rv && t0 < 0) begin t0 = k; m0 = l0_mul; end
            if (l7_rv && t7 < 0) begin t7 = k; m7 = l7_mul; end
        end
        check("t6_lat0_cycle", 32'(t0), 32'd2);
        check("t6_lat7_cycle", 32'(t7), 32'd9);
        check("t6_lat0_mul", 32'(m0), 32'd42);
        check("t6_lat7_mul", 32'(m7), 32'd42);

`ifdef MUL_ARB_STATS_EN
        check("stats_main", grant_cnt, 32'h0100_0100);
        check("stats_lat0", 32'(l0_cnt), 32'h0001);
        check("stats_lat7", 32'(l7_cnt), 32'h0001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single 4x4 multiplier datapath between NREQ requesters.
- Each requester presents an operand pair over a valid/ready handshake.
- The block grants one requester at a time and drives the shared multiplier's num1/num2 inputs, holding them stable.
- It waits MUL_LAT settle cycles, captures the 8-bit product, and returns it with the requester id over a valid/ready response channel.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 1, extra settle cycles before product capture (0..7; outside this range is an elaboration error).
- IDW, $clog2(NREQ), requester id width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_num1  in  4*NREQ  operand A; requester i uses bits [4i+3:4i].
- req_num2  in  4*NREQ  operand B; same packing as req_num1.
- mul_num1  out  4  to shared multiplier num1.
- mul_num2  out  4  to shared multiplier num2.
- mul_in  in  8  product from shared multiplier.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the served requester.
- rsp_mul  out  8  captured product.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - State is IDLE and rr_ptr is 0.
  - mul_num1, mul_num2, rsp_mul and rsp_id are 0.
  - rsp_valid and busy are 0; req_ready is all-zero.
  - Reset mid-operation abandons the operation; no response is produced after release.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[g] is asserted combinationally in the same cycle, and only in IDLE.
  - On the edge: latch num1/num2 of g into the operand registers, latch g into rsp_id, load lat_cnt=MUL_LAT, go to WAIT.
  - If no requester is valid, stay in IDLE.
- WAIT:
  - mul_num1/mul_num2 hold the latched operands and stay stable until the next grant.
  - If lat_cnt>0, decrement.
  - If lat_cnt==0, capture mul_in into rsp_mul and go to RESP.
  - WAIT lasts MUL_LAT+1 cycles.
- RESP:
  - rsp_valid=1; rsp_mul and rsp_id are held stable.
  - On rsp_valid&&rsp_ready: rr_ptr = (rsp_id+1) mod NREQ, go to IDLE.
- Latency: grant in cycle 0 gives rsp_valid first high in cycle MUL_LAT+2.
- Throughput: one operation per MUL_LAT+3 cycles minimum when rsp_ready is held high.
- Fairness: a requester that just completed has lowest priority for the next grant.
- Starvation-free: every continuously-valid requester is served within NREQ grants.
- Requester handshake rules:
  - A requester holds req_valid and its operands until it sees req_ready.
  - Dropping valid before grant is legal; that requester is not served.
  - Operand changes after grant have no effect.
- Arithmetic: product is the full unsigned 8 bits; no truncation (15*15=225).
- Back-pressure: rsp_ready low keeps the block in RESP indefinitely, with no new grants.

Optional Feature:
- Macro: MUL_ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt, 8*NREQ bits: per-requester 8-bit saturating count of completed responses.
  - Saturates at 255; cleared by reset.
  - Increments on the response handshake of that requester.
- When undefined: the port and the counters are absent.

Decomposition:
- Package mul_arb_pkg holds:
  - The state enum typedef (IDLE, WAIT, RESP).
  - Constants OP_W=4 and PROD_W=8.
  - A function rr_pick(valid, ptr) returning the index and a found flag.
- One natural sub-module: rr_arbiter.
  - Combinational rotating-priority picker.
  - Inputs req and ptr; outputs one-hot grant and index.
  - Instantiated once by the controller.

Test Plan (NREQ=4, MUL_LAT=1 unless stated):
- Reset then single request: req_valid=0001, num1=3, num2=5, rsp_ready=1.
  - req_ready=0001 in cycle 0.
  - rsp_valid in cycle 3 with rsp_id=0, rsp_mul=15; busy low in cycle 4.
- All four valid continuously, operands (i+1, 2).
  - Responses come in order id 0,1,2,3,0 with rsp_mul 2,4,6,8,2.
  - Grants are spaced 4 cycles apart.
- Max operands plus back-pressure: num1=15, num2=15, rsp_ready low for 5 cycles.
  - rsp_mul=225 stable throughout, no req_ready pulses, and the response completes on release.
- Round-robin pointer: serve id 2, then assert req_valid=0101.
  - Next grant goes to id 0 (scan 3,0), then id 2.
- Reset mid-WAIT: assert rst low during WAIT.
  - Outputs are 0 immediately, with no rsp_valid after release.
  - The next request is granted normally from rr_ptr 0.
- MUL_LAT=0 and MUL_LAT=7 builds, single request 6*7.
  - rsp_valid in cycle 2 and cycle 9 respectively, with rsp_mul=42.
  - With MUL_ARB_STATS_EN, grant_cnt[id] increments by 1 per response.
